// File: rtl/mips_instr_loader.sv
// mips_instr_loader
// Program loader for the pipelined MIPS core. It accepts abstract instruction
// requests over a valid/ready handshake, encodes each one into a 32-bit MIPS
// word (ADD, SUB, AND, OR, SLT, J, BEQ, BNE) and writes the words in order
// into instruction memory, starting at address 0.
//
// Optional feature macro: MIPS_LOADER_NOP_PAD_EN
//   When defined, three NOP words are written after the last instruction.
//   Three words of capacity are held back so the pad always fits.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, finish         session start pulse / end-of-requests pulse
//   req_valid, req_ready  request handshake
//   req_op, req_rs, req_rt, req_rd, req_imm   abstract instruction fields
//   mem_we, mem_addr, mem_wdata               registered memory write port
//   busy, done, full, word_count              session status
module mips_instr_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [25:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  localparam int CAP = 1 << ADDR_W;
`ifdef MIPS_LOADER_NOP_PAD_EN
  localparam int PAD = 3;
`else
  localparam int PAD = 0;
`endif
  localparam int CAP_EFF = CAP - PAD;
  localparam logic [ADDR_W:0] CAP_EFF_V = CAP_EFF[ADDR_W:0];
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_V = FIFO_DEPTH[PW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     fifo_wp;
  logic [PW-1:0]     fifo_rp;
  logic [PW:0]       fifo_cnt;
  logic [ADDR_W:0]   reserved;
  logic [ADDR_W-1:0] wr_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              pad_go;

  function automatic logic [31:0] encode(input logic [2:0]  op,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [25:0] imm);
    logic [31:0] w;
    unique case (op)
      3'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      3'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      3'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      3'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      3'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      3'd5:    w = {6'b000010, imm};
      3'd6:    w = {6'b000100, rs, rt, imm[15:0]};
      default: w = {6'b000101, rs, rt, imm[15:0]};
    endcase
    return w;
  endfunction

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_V);
  assign req_ready  = (state == S_LOAD) && !fifo_full && (reserved < CAP_EFF_V);
  assign push       = req_valid && req_ready;
  assign pop        = !fifo_empty;
  assign busy       = (state == S_LOAD) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

`ifdef MIPS_LOADER_NOP_PAD_EN
  logic [1:0] pad_left;
  // Pads go out only once every buffered instruction has been written.
  assign pad_go = (state == S_DRAIN) && fifo_empty && (pad_left != 2'd0);
`else
  assign pad_go = 1'b0;
`endif

  // Storage carries no reset; occupancy is tracked by the pointers below.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wp] <= encode(req_op, req_rs, req_rt, req_rd, req_imm);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_cnt   <= '0;
      reserved   <= '0;
      wr_ptr     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      full       <= 1'b0;
      word_count <= '0;
`ifdef MIPS_LOADER_NOP_PAD_EN
      pad_left   <= 2'd0;
`endif
    end else begin
      mem_we <= 1'b0;

      // Writer: one word per cycle, either a buffered instruction or a pad.
      if (pop || pad_go) begin
        mem_we     <= 1'b1;
        mem_addr   <= wr_ptr;
        mem_wdata  <= pop ? fifo_mem[fifo_rp] : '0;
        wr_ptr     <= wr_ptr + 1'b1;
        word_count <= word_count + 1'b1;
      end
`ifdef MIPS_LOADER_NOP_PAD_EN
      if (pad_go) begin
        pad_left <= pad_left - 2'd1;
      end
`endif

      if (push) begin
        fifo_wp <= fifo_wp + 1'b1;
      end
      if (pop) begin
        fifo_rp <= fifo_rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_cnt   <= '0;
            reserved   <= '0;
            wr_ptr     <= '0;
            full       <= 1'b0;
            word_count <= '0;
`ifdef MIPS_LOADER_NOP_PAD_EN
            pad_left   <= 2'd3;
`endif
          end
        end
        S_LOAD: begin
          if (push) begin
            reserved <= reserved + 1'b1;
          end
          // A handshake on the finish edge is still taken above.
          if (push && (reserved == CAP_EFF_V - 1'b1)) begin
            full  <= 1'b1;
            state <= S_DRAIN;
          end else if (finish) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Checked against the registered occupancy, so done follows the
          // cycle that carried the final write.
          if (fifo_empty && !pad_go) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
module tb_mips_instr_loader;

`ifdef MIPS_LOADER_NOP_PAD_EN
  localparam int PAD = 3;
`else
  localparam int PAD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance a: wide memory, shallow FIFO
  logic        a_start, a_finish, a_valid, a_ready;
  logic [2:0]  a_op;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [25:0] a_imm;
  logic        a_we;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_busy, a_done, a_full;
  logic [8:0]  a_wc;

  // Instance b: four-word memory
  logic        b_start, b_finish, b_valid, b_ready;
  logic [2:0]  b_op;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [25:0] b_imm;
  logic        b_we;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_busy, b_done, b_full;
  logic [2:0]  b_wc;

  mips_instr_loader #(.ADDR_W(8), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .finish(a_finish),
    .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
    .req_rs(a_rs), .req_rt(a_rt), .req_rd(a_rd), .req_imm(a_imm),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .busy(a_busy), .done(a_done), .full(a_full), .word_count(a_wc)
  );

  mips_instr_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .finish(b_finish),
    .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
    .req_rs(b_rs), .req_rt(b_rt), .req_rd(b_rd), .req_imm(b_imm),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .full(b_full), .word_count(b_wc)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  sb[$];
  logic [7:0] exp_addr;
  int   a_streak, a_max_streak;
  int   b_next, b_writes;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard consumer for instance a
  wr_t a_e;
  always @(negedge clk) begin
    if (a_we) begin
      a_streak++;
      if (a_streak > a_max_streak) a_max_streak = a_streak;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h expected no write", a_addr, a_wdata);
      end else begin
        a_e = sb.pop_front();
        check("a_write", {a_addr, a_wdata}, {a_e.addr, a_e.data});
      end
    end else begin
      a_streak = 0;
    end
  end

  // Instance b: every write must land at the next address in sequence
  always @(negedge clk) begin
    if (b_we) begin
      check("b_write_addr", b_addr, b_next);
      b_next++;
      b_writes++;
    end
  end

  task automatic a_send(input vec_t v, input logic fin, output logic acc);
    wr_t t;
    @(negedge clk);
    a_op = v.op; a_rs = v.rs; a_rt = v.rt; a_rd = v.rd; a_imm = v.imm;
    a_valid = 1'b1;
    a_finish = fin;
    acc = a_ready;
    @(posedge clk);
    if (acc) begin
      t.addr = exp_addr;
      t.data = v.exp;
      sb.push_back(t);
      exp_addr++;
    end
    #1;
    a_valid = 1'b0;
    a_finish = 1'b0;
  endtask

  task automatic a_pads();
    wr_t t;
    for (int i = 0; i < PAD; i++) begin
      t.addr = exp_addr;
      t.data = 32'h0;
      sb.push_back(t);
      exp_addr++;
    end
  endtask

  task automatic a_fin();
    @(negedge clk);
    a_finish = 1'b1;
    @(posedge clk);
    #1;
    a_finish = 1'b0;
    a_pads();
  endtask

  task automatic a_begin();
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic a_wait_done(input string name);
    int n = 0;
    while (!a_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, a_done, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   tries, acc_cnt, n;
    vec_t v;

    vecs[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  26'h0,       32'h00221820};
    vecs[1] = '{3'd1, 5'd5,  5'd6,  5'd7,  26'h155,     32'h00A63822};
    vecs[2] = '{3'd2, 5'd31, 5'd0,  5'd31, 26'h3ABCDEF, 32'h03E0F824};
    vecs[3] = '{3'd3, 5'd8,  5'd9,  5'd10, 26'h0,       32'h01095025};
    vecs[4] = '{3'd4, 5'd2,  5'd3,  5'd1,  26'h0,       32'h0043082A};
    vecs[5] = '{3'd5, 5'd7,  5'd0,  5'd0,  26'h3FFFFFF, 32'h0BFFFFFF};
    vecs[6] = '{3'd6, 5'd0,  5'd0,  5'd9,  26'h3FF1234, 32'h10001234};
    vecs[7] = '{3'd7, 5'd31, 5'd31, 5'd0,  26'h0008000, 32'h17FF8000};
    vecs[8] = '{3'd6, 5'd4,  5'd5,  5'd0,  26'h3,       32'h10850003};
    vecs[9] = '{3'd5, 5'd0,  5'd0,  5'd0,  26'h40,      32'h08000040};

    rst = 1'b1;
    a_start = 0; a_finish = 0; a_valid = 0; a_op = 0; a_rs = 0; a_rt = 0; a_rd = 0; a_imm = 0;
    b_start = 0; b_finish = 0; b_valid = 0; b_op = 0; b_rs = 0; b_rt = 0; b_rd = 0; b_imm = 0;
    exp_addr = '0; a_streak = 0; a_max_streak = 0; b_next = 0; b_writes = 0;
    #12;
    check("rst_a_ready", a_ready, 0);
    check("rst_a_mem", {a_we, a_addr, a_wdata}, 0);
    check("rst_a_status", {a_busy, a_done, a_full, a_wc}, 0);
    check("rst_b_all", {b_ready, b_we, b_addr, b_wdata, b_busy, b_done, b_full, b_wc}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD: write appears after the edge following the handshake
    a_begin();
    check("a_busy_load", {a_busy, a_done}, 2'b10);
    a_send(vecs[0], 1'b0, acc);
    check("lat_accept", acc, 1);
    check("lat_we_edge_k", a_we, 0);
    @(posedge clk); #1;
    check("lat_we_edge_k1", {a_we, a_addr, a_wdata}, {1'b1, 8'd0, 32'h00221820});
    @(posedge clk); #1;
    check("lat_we_one_cycle", a_we, 0);
    a_fin();
    a_wait_done("add_done");
    check("add_word_count", a_wc, 1 + PAD);
    check("add_sb_empty", sb.size(), 0);

    // Back-to-back BEQ, J, BNE
    a_begin();
    a_max_streak = 0;
    a_send(vecs[8], 1'b0, acc);
    a_send(vecs[9], 1'b0, acc);
    v = '{3'd7, 5'd1, 5'd0, 5'd0, 26'hFFFF, 32'h1420FFFF};
    a_send(v, 1'b0, acc);
    a_fin();
    a_wait_done("b2b_done");
    check("b2b_word_count", a_wc, 3 + PAD);
    check("b2b_consecutive", a_max_streak >= 3, 1);
    check("b2b_status", {a_busy, a_done, a_full}, 3'b010);
    check("b2b_sb_empty", sb.size(), 0);

    // Table of encodings, one per cycle
    a_begin();
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        a_send(vecs[i], 1'b0, acc);
        tries++;
      end while (!acc && tries < 20);
      check("table_accept", acc, 1);
    end
    a_fin();
    a_wait_done("table_done");
    check("table_word_count", a_wc, 10 + PAD);
    check("table_sb_empty", sb.size(), 0);

    // Eight requests through the depth-2 FIFO, finish on the last handshake
    a_begin();
    for (int i = 0; i < 8; i++) begin
      tries = 0;
      do begin
        a_send(vecs[(i * 3) % 10], (i == 7), acc);
        tries++;
      end while (!acc && tries < 20);
      check("stream_accept", acc, 1);
    end
    a_pads();
    @(posedge clk); #1;
    check("stream_ready_low", a_ready, 0);
    a_wait_done("stream_done");
    check("stream_word_count", a_wc, 8 + PAD);
    check("stream_sb_empty", sb.size(), 0);

    // Reset in the middle of a session
    a_begin();
    a_send(vecs[1], 1'b0, acc);
    a_send(vecs[2], 1'b0, acc);
    check("midrst_we_before", a_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_mem", {a_we, a_addr, a_wdata}, 0);
    check("midrst_status", {a_ready, a_busy, a_done, a_full, a_wc}, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {a_busy, a_done}, 2'b00);
    a_begin();
    a_send(vecs[3], 1'b0, acc);
    a_fin();
    a_wait_done("midrst_done");
    check("midrst_word_count", a_wc, 1 + PAD);
    check("midrst_sb_empty", sb.size(), 0);

    // Capacity limit on the four-word instance
    @(negedge clk);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b_op = 3'd0; b_rs = 5'(i); b_rt = 5'd1; b_rd = 5'd2;
      b_valid = 1'b1;
      acc = b_ready;
      @(posedge clk);
      if (acc) acc_cnt++;
    end
    #1;
    b_valid = 1'b0;
    check("cap_accepted", acc_cnt, 4 - PAD);
    check("cap_full", b_full, 1);
    check("cap_ready_low", b_ready, 0);
    n = 0;
    while (!b_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cap_done", b_done, 1);
    check("cap_word_count", b_wc, 4);
    check("cap_writes", b_writes, 4);
    repeat (3) @(negedge clk);
    check("cap_no_extra_write", b_writes, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
